pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Consumer end of the branch-address path. Holds the architectural PC and
//  selects next-PC from pc+4 or the jalr/branch/jal/mtvec/mepc targets.
//  Drives a single-outstanding request/response fetch handshake to
//  instruction memory and presents the fetched word to decode via valid/ready.
//  Sits between the target generator, the control unit and imem.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC loaded on RST; first fetch address
// PORTS
//  CLK           in   1   clock, all state on rising edge
//  RST           in   1   synchronous reset, active-high
//  PC_REDIRECT   in   1   1-cycle pulse: take non-sequential target this cycle
//  PC_SOURCE     in   3   0 pc+4, 1 jalr, 2 branch, 3 jal, 4 mtvec, 5 mepc; 6/7 = pc+4
//  JALR          in   32  jalr target
//  BRANCH        in   32  branch target
//  JAL           in   32  jal target
//  MTVEC         in   32  trap vector
//  MEPC          in   32  mret return address
//  IMEM_REQ      out  1   fetch request valid
//  IMEM_ADDR     out  32  fetch address
//  IMEM_READY    in   1   imem accepts request (IMEM_REQ & IMEM_READY = accepted)
//  IMEM_RVALID   in   1   response valid; exactly one per accepted request
//  IMEM_RDATA    in   32  instruction word
//  IR_VALID      out  1   IR/IR_PC hold a valid instruction
//  IR_READY      in   1   decode accepts IR
//  IR            out  32  instruction word
//  IR_PC         out  32  address IR was fetched from
//  PC            out  32  current architectural PC
//  TARGET_MISALIGN out 1  1-cycle pulse: redirect target rejected
// BEHAVIOUR
//  Reset: PC=IMEM_ADDR=RESET_VECTOR, IMEM_REQ=0, IR_VALID=0, IR=0, IR_PC=0,
//   TARGET_MISALIGN=0, kill=0, state=IDLE. RST wins over all inputs; in-flight
//   fetches are abandoned (imem shares RST).
//  FSM: IDLE -> REQ unconditionally (1 cycle after RST drops).
//   REQ  : IMEM_REQ=1, IMEM_ADDR=PC; on IMEM_READY -> WAIT.
//   WAIT : on IMEM_RVALID: if kill, clear kill -> REQ (data dropped);
//          else latch IR=IMEM_RDATA, IR_PC=PC, IR_VALID=1 -> HOLD.
//   HOLD : IR_VALID=1, IR/IR_PC stable; on IR_READY: PC<=PC+4, IR_VALID<=0 -> REQ.
//  IMEM_RVALID ignored outside WAIT.
//  Sequential latency, READY=1 and RVALID one cycle later: REQ@t, WAIT@t+1,
//   IR_VALID@t+2; with IR_READY=1, next REQ@t+3 (3 cycles/instr).
//  Redirect (PC_REDIRECT=1, target T per PC_SOURCE):
//   - T[1:0]!=0 -> TARGET_MISALIGN=1 next cycle; PC, state, IR unchanged.
//     Jalr target has bit0 cleared by generator; only bit1 is tested.
//   - else PC<=T and, by state:
//     REQ, !IMEM_READY : IMEM_ADDR changes to T next cycle, stay REQ (only
//                        case where IMEM_ADDR may change under IMEM_REQ).
//     REQ, IMEM_READY  : accepted fetch is stale -> WAIT with kill=1.
//     WAIT             : kill=1, unless RVALID this cycle, then drop -> REQ.
//     HOLD             : IR_VALID<=0 -> REQ; IR_READY same cycle counts as a
//                        transfer, decode flushes it. Redirect beats PC+4.
//     IDLE             : PC<=T, -> REQ.
//  PC+4 wraps mod 2^32: 32'hFFFF_FFFC -> 32'h0. No other arithmetic.
//  Max one outstanding request; IMEM_REQ never high in WAIT/HOLD.
// TESTING
//  1 Reset, RESET_VECTOR=32'h100, READY=1, RVALID 1 cycle later, IR_READY=1 ->
//    IMEM_ADDR 100,104,108 every 3 cycles; IR_PC matches; IR=RDATA.
//  2 In HOLD at PC=200, PC_SOURCE=3, JAL=32'h400, redirect + IR_READY same cycle
//    -> IR_VALID drops, next IMEM_ADDR=400, never 204.
//  3 In WAIT at PC=300, redirect BRANCH=32'h80, RVALID 2 cycles later with
//    32'hDEAD_BEEF -> IR_VALID stays 0, next fetch at 80.
//  4 Redirect JALR=32'h102 -> TARGET_MISALIGN pulses 1 cycle, PC unchanged;
//    then PC_SOURCE=4 MTVEC=32'h1C0 -> fetch at 1C0.
//  5 PC=32'hFFFF_FFFC, IR handshake -> next IMEM_ADDR=0.
//  6 IMEM_READY low 5 cycles in REQ, redirect on cycle 3 -> IMEM_ADDR switches
//    to target; RST asserted in WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: owns the architectural PC, selects next-PC, runs a
// single-outstanding imem request/response handshake and presents IR to decode.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PC_REDIRECT,
  input  logic [2:0]  PC_SOURCE,
  input  logic [31:0] JALR,
  input  logic [31:0] BRANCH,
  input  logic [31:0] JAL,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_READY,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        IR_VALID,
  input  logic        IR_READY,
  output logic [31:0] IR,
  output logic [31:0] IR_PC,
  output logic [31:0] PC,
  output logic        TARGET_MISALIGN
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        kill;
  logic        misalign;
  logic        misaligned;
  logic        take;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    target   = pc_plus4;
    case (PC_SOURCE)
      3'd1:    target = JALR;
      3'd2:    target = BRANCH;
      3'd3:    target = JAL;
      3'd4:    target = MTVEC;
      3'd5:    target = MEPC;
      default: target = pc_plus4;
    endcase
    // jalr targets arrive with bit0 already cleared, so only bit1 can be bad
    misaligned = (PC_SOURCE == 3'd1) ? target[1] : (target[1:0] != 2'b00);
    take       = PC_REDIRECT & ~misaligned;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      pc       <= RESET_VECTOR;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      kill     <= 1'b0;
      misalign <= 1'b0;
    end else begin
      misalign <= PC_REDIRECT & misaligned;
      case (state)
        S_IDLE: begin
          if (take) pc <= target;
          state <= S_REQ;
        end
        S_REQ: begin
          if (take) pc <= target;
          if (IMEM_READY) begin
            // a fetch accepted on the redirect edge is already stale
            kill  <= take;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (take) begin
            pc <= target;
            if (IMEM_RVALID) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              kill <= 1'b1;
            end
          end else if (IMEM_RVALID) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              ir       <= IMEM_RDATA;
              ir_pc    <= pc;
              ir_valid <= 1'b1;
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (take) begin
            pc       <= target;
            ir_valid <= 1'b0;
            state    <= S_REQ;
          end else if (IR_READY) begin
            pc       <= pc_plus4;
            ir_valid <= 1'b0;
            state    <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign IMEM_REQ        = (state == S_REQ);
  assign IMEM_ADDR       = pc;
  assign IR_VALID        = ir_valid;
  assign IR              = ir;
  assign IR_PC           = ir_pc;
  assign PC              = pc;
  assign TARGET_MISALIGN = misalign;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: imem responder, PC-stream reference model feeding a
// per-cycle scoreboard queue, directed scenarios followed by random traffic.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PC_REDIRECT = 1'b0;
  logic [2:0]  PC_SOURCE = 3'd0;
  logic [31:0] JALR = '0, BRANCH = '0, JAL = '0, MTVEC = '0, MEPC = '0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READY = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic        IR_VALID;
  logic        IR_READY = 1'b0;
  logic [31:0] IR, IR_PC, PC;
  logic        TARGET_MISALIGN;

  always #5 CLK = ~CLK;

  pc_fetch_ctrl #(.RESET_VECTOR(RV)) dut (
    .CLK(CLK), .RST(RST), .PC_REDIRECT(PC_REDIRECT), .PC_SOURCE(PC_SOURCE),
    .JALR(JALR), .BRANCH(BRANCH), .JAL(JAL), .MTVEC(MTVEC), .MEPC(MEPC),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_READY(IMEM_READY),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .IR_VALID(IR_VALID), .IR_READY(IR_READY), .IR(IR), .IR_PC(IR_PC),
    .PC(PC), .TARGET_MISALIGN(TARGET_MISALIGN)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- imem responder ----------------
  int unsigned ready_pct = 100;
  logic        ready_low = 1'b0;
  int unsigned rdelay = 0;
  logic        rdelay_rand = 1'b0;
  logic        use_beef = 1'b0;
  logic        busy = 1'b0;
  int unsigned cnt = 0;
  logic [31:0] odata = '0;

  always @(posedge CLK) begin
    if (RST) begin
      busy = 1'b0;
    end else begin
      if (busy && IMEM_RVALID) busy = 1'b0;
      if (IMEM_REQ && IMEM_READY) begin
        chk("one_outstanding", {31'b0, busy}, 32'd0);
        busy  = 1'b1;
        odata = use_beef ? 32'hDEAD_BEEF : memword(IMEM_ADDR);
        cnt   = rdelay_rand ? $urandom_range(3) : rdelay;
      end
    end
    #1;
    if (busy && cnt == 0) begin
      IMEM_RVALID = 1'b1;
      IMEM_RDATA  = odata;
    end else begin
      IMEM_RVALID = 1'b0;
      IMEM_RDATA  = $urandom;
      if (busy) cnt--;
    end
    IMEM_READY = !ready_low && ($urandom_range(99) < ready_pct);
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [31:0] pc;
    logic        mis;
    logic        rst;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  exp_t        mo;
  logic [31:0] m_pc = RV;
  logic [31:0] m_t;
  logic        m_bad;

  // architectural PC: advances by 4 per accepted IR, jumps on aligned redirect
  always @(posedge CLK) begin
    if (RST) begin
      m_pc   = RV;
      me.mis = 1'b0;
      me.rst = 1'b1;
    end else begin
      me.rst = 1'b0;
      case (PC_SOURCE)
        3'd1:    m_t = JALR;
        3'd2:    m_t = BRANCH;
        3'd3:    m_t = JAL;
        3'd4:    m_t = MTVEC;
        3'd5:    m_t = MEPC;
        default: m_t = m_pc + 32'd4;
      endcase
      m_bad  = (PC_SOURCE == 3'd1) ? m_t[1] : (m_t[1:0] != 2'b00);
      me.mis = PC_REDIRECT && m_bad;
      if (PC_REDIRECT && !m_bad) m_pc = m_t;
      else if (IR_VALID && IR_READY) m_pc = m_pc + 32'd4;
    end
    me.pc = m_pc;
    q.push_back(me);
  end

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      mo = q.pop_front();
      chk("pc", PC, mo.pc);
      chk("misalign", {31'b0, TARGET_MISALIGN}, {31'b0, mo.mis});
      if (mo.rst) begin
        chk("rst_ir_valid", {31'b0, IR_VALID}, 32'd0);
        chk("rst_imem_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("rst_imem_addr", IMEM_ADDR, RV);
        chk("rst_ir", IR, 32'd0);
        chk("rst_ir_pc", IR_PC, 32'd0);
      end else begin
        if (IMEM_REQ) chk("imem_addr", IMEM_ADDR, mo.pc);
        if (IR_VALID) begin
          chk("ir_pc", IR_PC, mo.pc);
          chk("ir_data", IR, memword(mo.pc));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic redirect(input logic [2:0] src, input logic [31:0] t);
    PC_SOURCE = src;
    case (src)
      3'd1:    JALR = t;
      3'd2:    BRANCH = t;
      3'd3:    JAL = t;
      3'd4:    MTVEC = t;
      3'd5:    MEPC = t;
      default: ;
    endcase
    PC_REDIRECT = 1'b1;
    tick();
    PC_REDIRECT = 1'b0;
  endtask

  task automatic wait_req(input string name, input logic [31:0] a);
    int n = 0;
    while (!IMEM_REQ && n < 50) begin tick(); n++; end
    chk({name, "_req"}, {31'b0, IMEM_REQ}, 32'd1);
    chk(name, IMEM_ADDR, a);
  endtask

  task automatic wait_ir(input string name, input logic [31:0] a);
    int n = 0;
    while (!IR_VALID && n < 50) begin tick(); n++; end
    chk({name, "_valid"}, {31'b0, IR_VALID}, 32'd1);
    chk(name, IR_PC, a);
  endtask

  initial begin
    logic [31:0] pcs [3];
    int unsigned cy [3];
    int          k;
    int          n;
    logic        seen;
    int unsigned xfers;

    // 1: sequential stream from the reset vector, 3 cycles per instruction
    IR_READY = 1'b1;
    tick(); tick();
    RST = 1'b0;
    k = 0; n = 0;
    while (k < 3 && n < 40) begin
      if (IR_VALID && IR_READY) begin pcs[k] = IR_PC; cy[k] = cyc; k++; end
      tick(); n++;
    end
    chk("t1_count", k, 3);
    for (int i = 0; i < k; i++) begin
      chk("t1_ir_pc", pcs[i], RV + 32'(4 * i));
      if (i > 0) chk("t1_period", cy[i] - cy[i-1], 3);
    end

    // 2: redirect beats PC+4 when it coincides with the IR handshake
    IR_READY = 1'b0;
    redirect(3'd3, 32'h200);
    wait_ir("t2_hold", 32'h200);
    IR_READY = 1'b1;
    redirect(3'd3, 32'h400);
    IR_READY = 1'b0;
    chk("t2_ir_drop", {31'b0, IR_VALID}, 32'd0);
    wait_req("t2_addr", 32'h400);

    // 3: redirect in WAIT drops the in-flight response
    rdelay = 2;
    redirect(3'd2, 32'h300);
    wait_req("t3_req300", 32'h300);
    use_beef = 1'b1;
    tick();
    use_beef = 1'b0;
    redirect(3'd2, 32'h80);
    seen = 1'b0; n = 0;
    while (!IMEM_REQ && n < 50) begin
      if (IR_VALID) seen = 1'b1;
      tick(); n++;
    end
    chk("t3_no_ir", {31'b0, seen}, 32'd0);
    wait_req("t3_addr", 32'h80);

    // 4: misaligned jalr target rejected, then trap vector taken
    rdelay = 0;
    redirect(3'd1, 32'h102);
    chk("t4_mis_pulse", {31'b0, TARGET_MISALIGN}, 32'd1);
    chk("t4_pc_kept", PC, 32'h80);
    tick();
    chk("t4_mis_clear", {31'b0, TARGET_MISALIGN}, 32'd0);
    redirect(3'd4, 32'h1C0);
    wait_req("t4_addr", 32'h1C0);

    // 5: PC+4 wraps at the top of the address space
    redirect(3'd5, 32'hFFFF_FFFC);
    wait_ir("t5_hold", 32'hFFFF_FFFC);
    IR_READY = 1'b1;
    tick();
    IR_READY = 1'b0;
    wait_req("t5_wrap", 32'h0);

    // 6: address may move under a stalled request; reset abandons a fetch
    ready_low = 1'b1;
    tick();
    redirect(3'd3, 32'h600);
    wait_req("t6_pre", 32'h600);
    tick(); tick();
    redirect(3'd3, 32'h500);
    chk("t6_req", {31'b0, IMEM_REQ}, 32'd1);
    chk("t6_switch", IMEM_ADDR, 32'h500);
    tick(); tick();
    ready_low = 1'b0;
    rdelay = 3;
    n = 0;
    while (IMEM_REQ && n < 20) begin tick(); n++; end
    chk("t6_in_wait", {31'b0, IMEM_REQ}, 32'd0);
    RST = 1'b1;
    tick();
    chk("t6_rst_pc", PC, RV);
    chk("t6_rst_ir", IR, 32'd0);
    chk("t6_rst_ir_valid", {31'b0, IR_VALID}, 32'd0);
    RST = 1'b0;

    // random traffic
    ready_pct = 70;
    rdelay_rand = 1'b1;
    xfers = 0;
    for (int c = 0; c < 3000; c++) begin
      IR_READY    = 1'($urandom_range(1));
      PC_REDIRECT = ($urandom_range(9) == 0);
      PC_SOURCE   = 3'($urandom_range(7));
      JALR   = $urandom & 32'hFFFF_FFFE;
      BRANCH = $urandom & (($urandom_range(3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      JAL    = $urandom & (($urandom_range(3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      MTVEC  = $urandom & (($urandom_range(3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      MEPC   = $urandom & (($urandom_range(3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      if ($urandom_range(7) == 0) JALR = JALR | 32'h2;
      RST = ($urandom_range(499) == 0);
      if (IR_VALID && IR_READY) xfers++;
      tick();
    end
    RST = 1'b0;
    PC_REDIRECT = 1'b0;
    chk("rand_progress", {31'b0, (xfers > 50)}, 32'd1);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
